// File: rtl/apb_protocol_checker_if.sv
// APB bus bundle seen by the protocol checker; the checker itself only observes (monitor modport).
interface apb_protocol_checker_if #(
  parameter int PADDR_WIDTH  = 32,
  parameter int PWDATA_WIDTH = 32,
  parameter int NUM_SEL      = 16
) ();
  logic [PADDR_WIDTH-1:0]  paddr;
  logic                    prwd;
  logic [PWDATA_WIDTH-1:0] pwdata;
  logic [NUM_SEL-1:0]      psel;
  logic                    penable;
  logic                    pready;
  logic                    pslverr;

  modport master  (output paddr, prwd, pwdata, psel, penable, input pready, pslverr);
  modport slave   (input paddr, prwd, pwdata, psel, penable, output pready, pslverr);
  modport monitor (input paddr, prwd, pwdata, psel, penable, pready, pslverr);
endinterface

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol checker: phase tracking, sticky error flags, transfer/wait statistics.
// Optional macro APB_CHK_SLVERR_CNT_EN enables the completion-with-PSLVERR counter.
module apb_protocol_checker #(
  parameter int PADDR_WIDTH    = 32,
  parameter int PWDATA_WIDTH   = 32,
  parameter int NUM_SEL        = 16,
  parameter int CNT_W          = 32,
  parameter int WAIT_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         pclock20,
  input  logic                         preset20,
  apb_protocol_checker_if.monitor      bus,
  input  logic                         chk_en,
  input  logic                         err_clr,
  output logic [7:0]                   err_flags,
  output logic                         err_irq,
  output logic [1:0]                   phase,
  output logic [CNT_W-1:0]             xfer_cnt,
  output logic [WAIT_W-1:0]            wait_max,
  output logic [CNT_W-1:0]             slverr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic [WAIT_W:0] TO_LIM   = (WAIT_W+1)'(TIMEOUT_CYCLES);
  localparam logic [WAIT_W:0] WAIT_ONE = (WAIT_W+1)'(1);

  state_e                  state_q, state_d;
  state_e                  phase_q, phase_d;
  logic [PADDR_WIDTH-1:0]  cap_addr_q, cap_addr_d;
  logic                    cap_rwd_q, cap_rwd_d;
  logic [PWDATA_WIDTH-1:0] cap_wdata_q, cap_wdata_d;
  logic [NUM_SEL-1:0]      cap_sel_q, cap_sel_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [WAIT_W-1:0]       wait_max_q, wait_max_d;
  logic [CNT_W-1:0]        xfer_cnt_q, xfer_cnt_d;
  logic [7:0]              err_flags_q, err_flags_d;
  logic                    err_irq_q, err_irq_d;

  logic [7:0]              err_raw;
  logic                    complete;
  logic                    access_ok;
  logic [WAIT_W-1:0]       cur_wait;
  logic [WAIT_W:0]         wait_inc;

  // The first access sample is evaluated while still in SETUP, so a zero-wait
  // transfer completes on the same sample that leaves SETUP.
  always_comb begin
    state_d     = state_q;
    cap_addr_d  = cap_addr_q;
    cap_rwd_d   = cap_rwd_q;
    cap_wdata_d = cap_wdata_q;
    cap_sel_d   = cap_sel_q;
    wait_cnt_d  = wait_cnt_q;
    wait_max_d  = wait_max_q;
    xfer_cnt_d  = xfer_cnt_q;
    err_raw     = '0;
    complete    = 1'b0;
    access_ok   = (bus.psel == cap_sel_q) && bus.penable;
    cur_wait    = (state_q == ST_ACCESS) ? wait_cnt_q : '0;
    wait_inc    = {1'b0, cur_wait} + WAIT_ONE;

    case (state_q)
      ST_IDLE: begin
        if (bus.penable) begin
          err_raw[1] = 1'b1;
        end else if (bus.psel != '0) begin
          cap_addr_d  = bus.paddr;
          cap_rwd_d   = bus.prwd;
          cap_wdata_d = bus.pwdata;
          cap_sel_d   = bus.psel;
          state_d     = ST_SETUP;
          if ((bus.psel & (bus.psel - NUM_SEL'(1))) != '0) err_raw[0] = 1'b1;
        end
      end
      ST_SETUP, ST_ACCESS: begin
        if (!access_ok) begin
          if (state_q == ST_SETUP) err_raw[2] = 1'b1;
          else                     err_raw[4] = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if ((bus.paddr != cap_addr_q) || (bus.prwd != cap_rwd_q) ||
              (cap_rwd_q && (bus.pwdata != cap_wdata_q)))
            err_raw[3] = 1'b1;
          if (bus.pready) begin
            complete = 1'b1;
            if (xfer_cnt_q != '1) xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
            if (cur_wait > wait_max_q) wait_max_d = cur_wait;
            state_d = ST_IDLE;
          end else begin
            wait_cnt_d = wait_inc[WAIT_W] ? '1 : wait_inc[WAIT_W-1:0];
            if ((TIMEOUT_CYCLES != 0) && (wait_inc == TO_LIM)) begin
              err_raw[5] = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_ACCESS;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_raw[6]  = bus.pslverr && !complete;
    phase_d     = complete ? ST_ACCESS : state_d;
    err_flags_d = err_clr ? (err_raw & {8{chk_en}})
                          : (err_flags_q | (err_raw & {8{chk_en}}));
    err_irq_d   = |err_flags_d;
  end

  always_ff @(posedge pclock20) begin
    if (preset20) begin
      state_q     <= ST_IDLE;
      phase_q     <= ST_IDLE;
      cap_addr_q  <= '0;
      cap_rwd_q   <= 1'b0;
      cap_wdata_q <= '0;
      cap_sel_q   <= '0;
      wait_cnt_q  <= '0;
      wait_max_q  <= '0;
      xfer_cnt_q  <= '0;
      err_flags_q <= '0;
      err_irq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cap_addr_q  <= cap_addr_d;
      cap_rwd_q   <= cap_rwd_d;
      cap_wdata_q <= cap_wdata_d;
      cap_sel_q   <= cap_sel_d;
      wait_cnt_q  <= wait_cnt_d;
      wait_max_q  <= wait_max_d;
      xfer_cnt_q  <= xfer_cnt_d;
      err_flags_q <= err_flags_d;
      err_irq_q   <= err_irq_d;
    end
  end

  assign err_flags = err_flags_q;
  assign err_irq   = err_irq_q;
  assign phase     = phase_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign wait_max  = wait_max_q;

`ifdef APB_CHK_SLVERR_CNT_EN
  logic [CNT_W-1:0] slverr_cnt_q, slverr_cnt_d;

  always_comb begin
    slverr_cnt_d = slverr_cnt_q;
    if (complete && bus.pslverr && (slverr_cnt_q != '1))
      slverr_cnt_d = slverr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge pclock20) begin
    if (preset20) slverr_cnt_q <= '0;
    else          slverr_cnt_q <= slverr_cnt_d;
  end

  assign slverr_cnt = slverr_cnt_q;
`else
  assign slverr_cnt = '0;
`endif

endmodule
